// File: rtl/detector_paso.sv
// Decodes barrier crossings from sensors A (outer) and B (inner) and keeps a saturating occupancy count.
// Latency: commit edge -> pulse plus updated ocupacion/lleno/vacio on the next cycle; all outputs registered.
// Backpressure: none; sensors are sampled every cycle, and stalled or invalid sequences park in ESPERA_LIBRE.
module detector_paso #(
    parameter int CAPACIDAD      = 8,
    parameter int ANCHO          = 4,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensorA,
    input  logic             sensorB,
    output logic             pulso_entrada,
    output logic             pulso_salida,
    output logic             rechazo,
    output logic             error,
    output logic [ANCHO-1:0] ocupacion,
    output logic             lleno,
    output logic             vacio
);
    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [ANCHO-1:0] CAP  = ANCHO'(CAPACIDAD);

    typedef enum logic [2:0] {
        REPOSO, ENT_A, ENT_AB, ENT_B, SAL_B, SAL_AB, SAL_A, ESPERA_LIBRE
    } estado_t;

    estado_t       estado, estadoSig;
    logic [TW-1:0] timer;
    logic [1:0]    ab;
    logic          errSec, finEnt, finSal, activo, timeoutHit;

    assign ab         = {sensorA, sensorB};
    assign activo     = (estado != REPOSO) && (estado != ESPERA_LIBRE);
    assign timeoutHit = activo && (estadoSig == estado) && (timer == TMAX);

    always_comb begin
        estadoSig = estado;
        errSec    = 1'b0;
        finEnt    = 1'b0;
        finSal    = 1'b0;
        case (estado)
            REPOSO: case (ab)
                2'b10:   estadoSig = ENT_A;
                2'b01:   estadoSig = SAL_B;
                2'b11:   begin estadoSig = ESPERA_LIBRE; errSec = 1'b1; end
                default: ;
            endcase
            ENT_A: case (ab)
                2'b11:   estadoSig = ENT_AB;
                2'b00:   estadoSig = REPOSO;
                2'b01:   begin estadoSig = ESPERA_LIBRE; errSec = 1'b1; end
                default: ;
            endcase
            ENT_AB: case (ab)
                2'b01:   estadoSig = ENT_B;
                2'b10:   estadoSig = ENT_A;
                2'b00:   begin estadoSig = ESPERA_LIBRE; errSec = 1'b1; end
                default: ;
            endcase
            ENT_B: case (ab)
                2'b00:   begin estadoSig = REPOSO; finEnt = 1'b1; end
                2'b11:   estadoSig = ENT_AB;
                2'b10:   begin estadoSig = ESPERA_LIBRE; errSec = 1'b1; end
                default: ;
            endcase
            SAL_B: case (ab)
                2'b11:   estadoSig = SAL_AB;
                2'b00:   estadoSig = REPOSO;
                2'b10:   begin estadoSig = ESPERA_LIBRE; errSec = 1'b1; end
                default: ;
            endcase
            SAL_AB: case (ab)
                2'b10:   estadoSig = SAL_A;
                2'b01:   estadoSig = SAL_B;
                2'b00:   begin estadoSig = ESPERA_LIBRE; errSec = 1'b1; end
                default: ;
            endcase
            SAL_A: case (ab)
                2'b00:   begin estadoSig = REPOSO; finSal = 1'b1; end
                2'b11:   estadoSig = SAL_AB;
                2'b01:   begin estadoSig = ESPERA_LIBRE; errSec = 1'b1; end
                default: ;
            endcase
            ESPERA_LIBRE: if (ab == 2'b00) estadoSig = REPOSO;
            default: estadoSig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= REPOSO;
            timer         <= '0;
            ocupacion     <= '0;
            lleno         <= 1'b0;
            vacio         <= 1'b1;
            pulso_entrada <= 1'b0;
            pulso_salida  <= 1'b0;
            rechazo       <= 1'b0;
            error         <= 1'b0;
        end else begin
            pulso_entrada <= 1'b0;
            pulso_salida  <= 1'b0;
            rechazo       <= 1'b0;
            error         <= errSec | timeoutHit;
            // a legal move on the last allowed edge wins because timeoutHit requires no transition
            estado <= timeoutHit ? ESPERA_LIBRE : estadoSig;
            if (!activo || (estadoSig != estado) || timeoutHit)
                timer <= '0;
            else
                timer <= timer + 1'b1;
            if (finEnt) begin
                if (ocupacion < CAP) begin
                    ocupacion     <= ocupacion + 1'b1;
                    pulso_entrada <= 1'b1;
                    lleno         <= ((ocupacion + 1'b1) == CAP);
                    vacio         <= 1'b0;
                end else begin
                    rechazo <= 1'b1;
                end
            end
            if (finSal) begin
                if (ocupacion != '0) begin
                    ocupacion    <= ocupacion - 1'b1;
                    pulso_salida <= 1'b1;
                    lleno        <= 1'b0;
                    vacio        <= (ocupacion == ANCHO'(1));
                end else begin
                    rechazo <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_detector_paso.sv
// Directed bench for detector_paso with CAPACIDAD=3, ANCHO=2, TIMEOUT_CICLOS=16.
module tb_detector_paso;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensorA = 1'b0;
    logic       sensorB = 1'b0;
    logic       pulso_entrada, pulso_salida, rechazo, error, lleno, vacio;
    logic [1:0] ocupacion;

    int checks = 0;
    int failures = 0;
    int cntEnt, cntSal, cntRech, cntErr;

    detector_paso #(.CAPACIDAD(3), .ANCHO(2), .TIMEOUT_CICLOS(16)) dut (
        .clk(clk), .rst_n(rst_n), .sensorA(sensorA), .sensorB(sensorB),
        .pulso_entrada(pulso_entrada), .pulso_salida(pulso_salida),
        .rechazo(rechazo), .error(error), .ocupacion(ocupacion),
        .lleno(lleno), .vacio(vacio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clr();
        cntEnt = 0; cntSal = 0; cntRech = 0; cntErr = 0;
    endtask

    // Drive sensors for n edges, counting high cycles of each pulse at the following negedges.
    task automatic hold(input logic a, input logic b, input int n);
        sensorA = a;
        sensorB = b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cntEnt  += int'(pulso_entrada);
            cntSal  += int'(pulso_salida);
            cntRech += int'(rechazo);
            cntErr  += int'(error);
        end
    endtask

    task automatic entrada();
        hold(0, 0, 3); hold(1, 0, 3); hold(1, 1, 3); hold(0, 1, 3); hold(0, 0, 3);
    endtask

    task automatic salida();
        hold(0, 0, 3); hold(0, 1, 3); hold(1, 1, 3); hold(1, 0, 3); hold(0, 0, 3);
    endtask

    initial begin
        clr();
        repeat (2) @(negedge clk);
        chk("reset_ocupacion", ocupacion, 0);
        chk("reset_vacio", vacio, 1);
        chk("reset_lleno", lleno, 0);
        chk("reset_pulsos", {pulso_entrada, pulso_salida, rechazo, error}, 0);
        rst_n = 1'b1;
        hold(0, 0, 2);

        // 1: single entry, checking latency of the commit edge
        clr();
        hold(1, 0, 3); hold(1, 1, 3); hold(0, 1, 3);
        chk("t1_before_commit", ocupacion, 0);
        hold(0, 0, 1);
        chk("t1_pulse_now", pulso_entrada, 1);
        chk("t1_ocup_now", ocupacion, 1);
        chk("t1_vacio_now", vacio, 0);
        hold(0, 0, 2);
        chk("t1_pulse_gone", pulso_entrada, 0);
        chk("t1_cnt_ent", cntEnt, 1);
        chk("t1_cnt_err", cntErr, 0);

        // 2: fill to capacity, then one exit
        clr();
        entrada(); entrada();
        chk("t2_ocup_full", ocupacion, 3);
        chk("t2_lleno", lleno, 1);
        salida();
        chk("t2_ocup_after_exit", ocupacion, 2);
        chk("t2_lleno_clear", lleno, 0);
        chk("t2_cnt_sal", cntSal, 1);

        // 3: rejection at full and at empty
        clr();
        entrada();
        chk("t3_ocup_refill", ocupacion, 3);
        entrada();
        chk("t3_rech_full", cntRech, 1);
        chk("t3_ocup_stays", ocupacion, 3);
        salida(); salida(); salida();
        chk("t3_ocup_empty", ocupacion, 0);
        chk("t3_vacio", vacio, 1);
        salida();
        chk("t3_rech_total", cntRech, 2);
        chk("t3_ocup_no_wrap", ocupacion, 0);
        chk("t3_cnt_ent", cntEnt, 1);
        chk("t3_cnt_sal", cntSal, 3);

        // 4: aborted entry leaves the count alone and returns to idle
        clr();
        hold(0, 0, 3); hold(1, 0, 3); hold(1, 1, 3); hold(1, 0, 3); hold(0, 0, 3);
        chk("t4_no_pulses", cntEnt + cntSal + cntRech + cntErr, 0);
        chk("t4_ocup", ocupacion, 0);
        entrada();
        chk("t4_entry_after_abort", ocupacion, 1);

        // 5: timeout after 16 cycles in ENT_A, then the tail of the sequence is ignored
        clr();
        hold(1, 0, 16);
        chk("t5_no_err_yet", cntErr, 0);
        hold(1, 0, 1);
        chk("t5_timeout_err", error, 1);
        hold(1, 0, 3); hold(1, 1, 3); hold(0, 1, 3); hold(0, 0, 3);
        chk("t5_cnt_err", cntErr, 1);
        chk("t5_no_commit", cntEnt, 0);
        chk("t5_ocup", ocupacion, 1);
        // legal move on the timeout edge takes priority
        clr();
        hold(1, 0, 16); hold(1, 1, 3); hold(0, 1, 3); hold(0, 0, 3);
        chk("t5_prio_err", cntErr, 0);
        chk("t5_prio_ocup", ocupacion, 2);

        // 6: simultaneous block, no timeout in ESPERA_LIBRE, async reset mid-crossing
        clr();
        hold(1, 1, 1);
        chk("t6_err_11", error, 1);
        hold(1, 1, 20);
        chk("t6_no_wait_timeout", cntErr, 1);
        hold(0, 0, 2);
        hold(1, 0, 3); hold(1, 1, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ocup", ocupacion, 0);
        chk("t6_rst_flags", {lleno, vacio}, 2'b01);
        chk("t6_rst_pulses", {pulso_entrada, pulso_salida, rechazo, error}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        hold(1, 1, 1);
        chk("t6_err_after_release", error, 1);
        hold(0, 1, 3); hold(0, 0, 3);
        chk("t6_no_commit_after_rst", cntEnt + cntSal, 0);
        chk("t6_ocup_final", ocupacion, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
